// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: DEPTH-byte FIFO feeding a b_tick-paced serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_buffered #(
    parameter int DEPTH         = 8,
    parameter int TICKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       b_tick,
    input  logic       i_wr,
    input  logic [7:0] i_din,
    output logic       o_full,
    output logic       o_empty,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_tx_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic       w_push;
    logic       w_pop;
    logic [7:0] w_rd_data;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign w_push    = i_wr && !o_full;
    assign w_rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    state_t        r_state;
    logic [TW-1:0] r_tick_cnt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          r_busy;
    logic          r_done;

    state_t        w_state_n;
    logic [TW-1:0] w_tick_n;
    logic [2:0]    w_bit_n;
    logic [7:0]    w_shift_n;
    logic          w_tx_n;
    logic          w_done_n;
    logic          w_tick_last;

`ifdef UART_TX_PARITY_EN
    logic r_par;
    logic w_par_n;
`endif

    assign w_tick_last = b_tick && (r_tick_cnt == TICK_LAST);

    always_comb begin
        w_state_n = r_state;
        w_tick_n  = r_tick_cnt;
        w_bit_n   = r_bit_cnt;
        w_shift_n = r_shift;
        w_done_n  = 1'b0;
        w_pop     = 1'b0;
        if (b_tick && r_state != IDLE)
            w_tick_n = w_tick_last ? '0 : r_tick_cnt + 1'b1;
        case (r_state)
            IDLE: begin
                if (b_tick && !o_empty) begin
                    w_pop     = 1'b1;
                    w_shift_n = w_rd_data;
                    w_tick_n  = '0;
                    w_state_n = START;
                end
            end
            START: begin
                if (w_tick_last) begin
                    w_state_n = DATA;
                    w_bit_n   = '0;
                end
            end
            DATA: begin
                if (w_tick_last) begin
                    w_shift_n = {1'b0, r_shift[7:1]};
                    w_bit_n   = r_bit_cnt + 1'b1;
`ifdef UART_TX_PARITY_EN
                    if (r_bit_cnt == 3'd7) w_state_n = PARITY;
`else
                    if (r_bit_cnt == 3'd7) w_state_n = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_tick_last) w_state_n = STOP;
            end
`endif
            STOP: begin
                if (w_tick_last) begin
                    w_done_n = 1'b1;
                    // Chain the next queued byte straight into its start bit
                    if (!o_empty) begin
                        w_pop     = 1'b1;
                        w_shift_n = w_rd_data;
                        w_state_n = START;
                    end else begin
                        w_state_n = IDLE;
                    end
                end
            end
            default: w_state_n = IDLE;
        endcase

`ifdef UART_TX_PARITY_EN
        w_par_n = w_pop ? ^w_rd_data : r_par;
`endif

        case (w_state_n)
            START:   w_tx_n = 1'b0;
            DATA:    w_tx_n = w_shift_n[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  w_tx_n = r_par;
`endif
            default: w_tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_tick_cnt <= w_tick_n;
            r_bit_cnt  <= w_bit_n;
            r_shift    <= w_shift_n;
            r_tx       <= w_tx_n;
            r_busy     <= (w_state_n != IDLE);
            r_done     <= w_done_n;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_par <= 1'b0;
        else     r_par <= w_par_n;
    end
`endif

    assign o_tx      = r_tx;
    assign o_busy    = r_busy;
    assign o_tx_done = r_done;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered: pushed bytes are queued and a
// line monitor decodes each frame off o_tx and compares in order.
module tb_uart_tx_buffered;

`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CLK = NBITS * 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_wr = 1'b0;
    logic [7:0] i_din = 8'h00;
    logic       tick_en = 1'b0;
    logic       man_tick = 1'b0;
    int         ph = 0;
    logic       b_tick;
    logic       o_full, o_empty, o_tx, o_busy, o_tx_done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int busy_falls = 0;
    int busy_rises = 0;
    logic [7:0] exp_q[$];

    assign b_tick = (tick_en && ph == 0) || man_tick;

    uart_tx_buffered #(.DEPTH(8), .TICKS_PER_BIT(8)) dut (
        .clk(clk), .rst(rst), .b_tick(b_tick),
        .i_wr(i_wr), .i_din(i_din),
        .o_full(o_full), .o_empty(o_empty), .o_tx(o_tx),
        .o_busy(o_busy), .o_tx_done(o_tx_done)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(negedge clk);
        ph = (ph + 1) % 4;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Event counters for o_tx_done pulses and o_busy edges
    initial begin : evcnt
        logic pb;
        pb = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) pb = 1'b0;
            else begin
                if (o_tx_done) done_cnt++;
                if (pb && !o_busy) busy_falls++;
                if (!pb && o_busy) busy_rises++;
                pb = o_busy;
            end
        end
    end

    // Line monitor: resync on each falling edge, sample mid-bit
    initial begin : mon
        logic       prev, act_f, par;
        int         cnt, k;
        logic [7:0] sh, e;
        prev = 1'b1; act_f = 1'b0; cnt = 0; sh = '0; par = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                act_f = 1'b0;
                prev  = 1'b1;
            end else begin
                if (!act_f) begin
                    if (prev && !o_tx) begin
                        act_f = 1'b1;
                        cnt   = 0;
                    end
                end else cnt++;
                if (act_f && (cnt % 32) == 16) begin
                    k = cnt / 32;
                    if (k == 0) chk("start_bit", o_tx, 0);
                    else if (k <= 8) sh[k-1] = o_tx;
                    else if (k == NBITS - 1) begin
                        chk("stop_bit", o_tx, 1);
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_frame got=%0h want=none", sh);
                        end else begin
                            e = exp_q.pop_front();
                            chk("frame_byte", sh, e);
`ifdef UART_TX_PARITY_EN
                            chk("parity_bit", par, ^e);
`endif
                        end
                        act_f = 1'b0;
                    end else par = o_tx;
                end
                prev = o_tx;
            end
        end
    end

    task automatic wr(input logic [7:0] b, input bit keep);
        @(negedge clk);
        i_wr  = 1'b1;
        i_din = b;
        if (keep) exp_q.push_back(b);
    endtask

    task automatic wr_end();
        @(negedge clk);
        i_wr = 1'b0;
    endtask

    task automatic wait_done(input int target, input string name);
        int n;
        n = 0;
        while (done_cnt < target && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk(name, done_cnt >= target, 1);
    endtask

    task automatic frame_len(input string name);
        int n, len;
        n = 0;
        len = 0;
        while (!o_busy && n < 64) begin
            @(negedge clk);
            n++;
        end
        while (o_busy && len < 1000) begin
            @(negedge clk);
            len++;
        end
        chk(name, len, FRAME_CLK);
    endtask

    initial begin : stim
        int d0, f0, r0, n;
        tick_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx", o_tx, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_tx_done, 0);
        chk("rst_empty", o_empty, 1);
        chk("rst_full", o_full, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single frame 0x55
        d0 = done_cnt;
        wr(8'h55, 1);
        wr_end();
        frame_len("len_55");
        repeat (2) @(negedge clk);
        chk("done_55", done_cnt - d0, 1);

        // Three back-to-back frames
        d0 = done_cnt;
        f0 = busy_falls;
        wr(8'hA3, 1);
        wr(8'h0F, 1);
        wr(8'hFF, 1);
        wr_end();
        chk("empty_queued", o_empty, 0);
        wait_done(d0 + 1, "wait_a3");
        chk("empty_ff_left", o_empty, 0);
        wait_done(d0 + 2, "wait_0f");
        chk("empty_ff_popped", o_empty, 1);
        wait_done(d0 + 3, "wait_ff");
        repeat (2) @(negedge clk);
        chk("no_gap", busy_falls - f0, 1);
        chk("done_x3", done_cnt - d0, 3);

        // Fill with ticks stopped, overflow, then push+pop while full
        tick_en = 1'b0;
        d0 = done_cnt;
        for (int i = 0; i < 9; i++) begin
            wr(8'(i), i < 8);
            if (i == 8) chk("full_after_8", o_full, 1);
        end
        wr_end();
        chk("full_after_drop", o_full, 1);
        man_tick = 1'b1;
        i_wr     = 1'b1;
        i_din    = 8'h99;
        @(negedge clk);
        man_tick = 1'b0;
        i_wr     = 1'b0;
        chk("full_after_pushpop", o_full, 0);
        chk("busy_after_pop", o_busy, 1);
        tick_en = 1'b1;
        wait_done(d0 + 8, "wait_fill");
        repeat (4) @(negedge clk);
        chk("fill_drained", exp_q.size(), 0);

        // Reset in the middle of 0xC3 with two bytes queued
        wr(8'hC3, 1);
        wr(8'h11, 1);
        wr(8'h22, 1);
        wr_end();
        n = 0;
        while (!o_busy && n < 64) begin
            @(negedge clk);
            n++;
        end
        repeat (100) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_tx", o_tx, 1);
        chk("midrst_busy", o_busy, 0);
        chk("midrst_empty", o_empty, 1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        r0 = busy_rises;
        repeat (700) @(negedge clk);
        chk("post_rst_idle", busy_rises - r0, 0);
        chk("post_rst_tx", o_tx, 1);

        // 0x07: parity bit 1 and 11-bit frame when parity is built in
        d0 = done_cnt;
        wr(8'h07, 1);
        wr_end();
        frame_len("len_07");
        repeat (2) @(negedge clk);
        chk("done_07", done_cnt - d0, 1);
        chk("final_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
